// File: rtl/rrf_alloc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rrf_alloc_ctrl_pkg : shared constants for the rename register file sequencer
// Revision: 1.0
// ============================================================================
package rrf_alloc_ctrl_pkg;

    localparam int RRF_NUM_DEF = 64;
    localparam int RRF_SEL_DEF = 6;
    localparam int DATA_LEN    = 32;
    localparam int DISP_WIDTH  = 2;

endpackage : rrf_alloc_ctrl_pkg
`default_nettype wire

// File: rtl/rrf_alloc_ctrl_ptr_add.sv
`default_nettype none
// ============================================================================
// rrf_alloc_ctrl_ptr_add : ring pointer advance by 0..3, wrapping mod 2**SEL
// Revision: 1.0
// ============================================================================
module rrf_alloc_ctrl_ptr_add #(
    parameter int SEL = 6
) (
    input  logic [SEL-1:0] ptr,
    input  logic [1:0]     inc,
    output logic [SEL-1:0] sum
);

    assign sum = ptr + SEL'(inc);

endmodule : rrf_alloc_ctrl_ptr_add
`default_nettype wire

// File: rtl/rrf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// rrf_alloc_ctrl : in-order RRF tag allocation / commit release sequencer
// Revision: 1.0
// ============================================================================
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
#(
    parameter int RRF_NUM = RRF_NUM_DEF,
    parameter int RRF_SEL = RRF_SEL_DEF
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               dispatch_valid_i,
    input  logic [1:0]         req_num_i,
    output logic               stall_o,
    output logic               alloc_en0_o,
    output logic [RRF_SEL-1:0] alloc_tag0_o,
    output logic               alloc_en1_o,
    output logic [RRF_SEL-1:0] alloc_tag1_o,
    input  logic [1:0]         com_num_i,
    output logic [RRF_SEL-1:0] com_tag0_o,
    output logic [RRF_SEL-1:0] com_tag1_o,
    input  logic               flush_i,
    input  logic [RRF_SEL-1:0] flush_branch_tag_i,
    output logic [RRF_SEL:0]   freenum_o
);

    localparam logic [RRF_SEL:0] NUM_W = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_SEL-1:0] alloc_ptr;
    logic [RRF_SEL-1:0] com_ptr;
    logic [RRF_SEL:0]   freenum;

    logic [RRF_SEL-1:0] alloc_ptr_inc;
    logic [RRF_SEL-1:0] alloc_ptr_adv;
    logic [RRF_SEL-1:0] com_ptr_inc;
    logic [RRF_SEL-1:0] com_ptr_n;
    logic [RRF_SEL-1:0] flush_ptr;
    logic [RRF_SEL-1:0] flush_span;
    logic [RRF_SEL-1:0] branch_dist;
    logic [RRF_SEL:0]   occ;
    logic [RRF_SEL:0]   freenum_next;
    logic               stall;
    logic               acc;
    logic [1:0]         alloc_count;

    rrf_alloc_ctrl_ptr_add #(.SEL(RRF_SEL)) u_alloc_inc (
        .ptr(alloc_ptr), .inc(2'd1), .sum(alloc_ptr_inc));
    rrf_alloc_ctrl_ptr_add #(.SEL(RRF_SEL)) u_alloc_adv (
        .ptr(alloc_ptr), .inc(alloc_count), .sum(alloc_ptr_adv));
    rrf_alloc_ctrl_ptr_add #(.SEL(RRF_SEL)) u_com_inc (
        .ptr(com_ptr), .inc(2'd1), .sum(com_ptr_inc));
    rrf_alloc_ctrl_ptr_add #(.SEL(RRF_SEL)) u_com_adv (
        .ptr(com_ptr), .inc(com_num_i), .sum(com_ptr_n));
    rrf_alloc_ctrl_ptr_add #(.SEL(RRF_SEL)) u_flush_inc (
        .ptr(flush_branch_tag_i), .inc(2'd1), .sum(flush_ptr));

    // Stall sees only the registered count; same-cycle frees help next cycle.
    // Gating with reset_n_i keeps the allocate enables quiet while in reset.
    always_comb begin
        stall       = reset_n_i & dispatch_valid_i & ~flush_i
                    & (freenum < (RRF_SEL+1)'(req_num_i));
        acc         = reset_n_i & dispatch_valid_i & ~flush_i & ~stall;
        alloc_count = acc ? req_num_i : 2'd0;
    end

    // Recovery rebuilds the free count from the surviving window length.
    always_comb begin
        flush_span = flush_branch_tag_i - com_ptr_n;
        occ        = {1'b0, flush_span} + (RRF_SEL+1)'(1);
        if (flush_i) begin
            freenum_next = NUM_W - occ;
        end else begin
            freenum_next = freenum - (RRF_SEL+1)'(alloc_count)
                         + (RRF_SEL+1)'(com_num_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            alloc_ptr <= '0;
            com_ptr   <= '0;
            freenum   <= NUM_W;
        end else begin
            alloc_ptr <= flush_i ? flush_ptr : alloc_ptr_adv;
            com_ptr   <= com_ptr_n;
            freenum   <= freenum_next;
        end
    end

    assign stall_o      = stall;
    assign alloc_en0_o  = acc & (req_num_i >= 2'd1);
    assign alloc_en1_o  = acc & (req_num_i == 2'd2);
    assign alloc_tag0_o = alloc_ptr;
    assign alloc_tag1_o = alloc_ptr_inc;
    assign com_tag0_o   = com_ptr;
    assign com_tag1_o   = com_ptr_inc;
    assign freenum_o    = freenum;

    assign branch_dist = flush_branch_tag_i - com_ptr;

    a_req_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        dispatch_valid_i |-> (req_num_i != 2'd3));
    a_com_bound : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (RRF_SEL+1)'(com_num_i) <= (NUM_W - freenum));
    a_branch_live : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        flush_i |-> ((com_num_i == 2'd0) || (branch_dist >= RRF_SEL'(com_num_i))));

endmodule : rrf_alloc_ctrl
`default_nettype wire
